ram_responder: RTL and testbench
================================

# ram_responder

Word-addressed single-port memory that services one read or write request at a time with a fixed, parameterised access latency and a busy/done handshake. It is the memory end of the cache-to-RAM interface: the cache presents address, data and mode, watches `response` fall to 0, then takes `out`. Behavioural model for simulation and the stand-in backing store for cache bring-up.

## Interface
- `SIZE_RAM`, 4096: number of 32-bit words; power of two, ≥ 2.
- `LATENCY`, 4: clock edges from request acceptance to completion; ≥ 1.
- `clk`  input  1  clock; all state updates on rising edge.
- `rst`  input  1  reset; asynchronous, active-high.
- `req`  input  1  request strobe; sampled only in IDLE.
- `mode`  input  1  0 = read, 1 = write.
- `address`  input  32  word address.
- `data`  input  32  write data.
- `response`  output  1  1 = busy, 0 = idle/finished.
- `valid`  output  1  one-cycle pulse when a request completes.
- `out`  output  32  read data of the most recent completed read.
- `err`  output  1  present only with `RAM_RANGE_CHECK_EN`; see Configuration.

## Operation
- Storage: `SIZE_RAM` × 32-bit array; contents not affected by `rst`; uninitialised words read as X in simulation.
- Index = `address` mod `SIZE_RAM` (low $clog2(SIZE_RAM) bits); upper bits ignored.
- FSM states: IDLE, BUSY.
  - IDLE, `req`=1: capture `mode`, `address`, `data` into internal registers; load counter with `LATENCY`; `response`←1; go BUSY.
  - IDLE, `req`=0: hold.
  - BUSY, counter > 1: decrement; inputs ignored (`req`, `address`, `data`, `mode` may change freely).
  - BUSY, counter = 1: perform access with captured values; read → `out`←mem[index]; write → mem[index]←captured data, `out` unchanged; `response`←0; `valid`←1; go IDLE.
- `valid` is 0 on every edge except the completion edge.
- Counter width $clog2(LATENCY+1); no wrap possible.
- `req` arriving while BUSY is dropped, not queued; requester must wait for `response`=0.

## Timing
- Reset values: `response`=0, `valid`=0, `out`=0, `err`=0, state IDLE, counter 0.
- Request accepted at edge N → `response`=1 after N; completion at edge N+LATENCY → `response`=0, `valid`=1, `out` updated after N+LATENCY.
- Earliest next acceptance: edge N+LATENCY+1 (IDLE); back-to-back period = LATENCY+1 cycles.
- `req` high on the completion edge itself is ignored (state still BUSY).
- Read-after-write to same index returns the written word.
- `rst` mid-BUSY: request aborted, no memory write, `out` cleared to 0, outputs to reset values immediately.

## Configuration
- `RAM_RANGE_CHECK_EN` defined: `err` port exists; on a request with `address` ≥ `SIZE_RAM`, full LATENCY handshake still runs, but at completion no memory access occurs, `out` unchanged, `err`←1 (held until next completion or reset; cleared at next in-range completion).
- Not defined: no `err` port; out-of-range addresses wrap modulo `SIZE_RAM`.

## Test plan
- Reset: assert `rst` mid-cycle with no clock → `response`=0, `valid`=0, `out`=0 immediately.
- Write 0xDEADBEEF to 0x010, then read 0x010 → `response` high exactly 4 cycles each, `valid` pulse on completion, `out`=0xDEADBEEF; `out` unchanged after the write.
- Busy rejection: read 0x020 accepted, pulse `req` write to 0x020 with 0x12345678 two cycles later → ignored; subsequent read 0x020 returns prior contents.
- Wrap (macro off): write 0xA5A5A5A5 to 0x1005, read 0x005 → 0xA5A5A5A5. Macro on: same write → `err`=1, read 0x005 returns old value, `err` cleared.
- Reset mid-write: write 0x0BADF00D to 0x030, assert `rst` after 2 cycles → read 0x030 returns prior contents, not 0x0BADF00D.
- Back-to-back: `req` held high with alternating addresses → acceptances every 5 cycles, one `valid` per request.

Source files
------------

// File: rtl/ram_responder_if.sv
// Cache-to-RAM request/response bundle: the cache drives master, the memory drives slave.
// The err signal exists only when RAM_RANGE_CHECK_EN is defined.
interface ram_responder_if;
    logic        req;
    logic        mode;
    logic [31:0] address;
    logic [31:0] data;
    logic        response;
    logic        valid;
    logic [31:0] out;
`ifdef RAM_RANGE_CHECK_EN
    logic        err;
`endif

    modport master (
        output req, mode, address, data,
        input  response, valid, out
`ifdef RAM_RANGE_CHECK_EN
        , input err
`endif
    );

    modport slave (
        input  req, mode, address, data,
        output response, valid, out
`ifdef RAM_RANGE_CHECK_EN
        , output err
`endif
    );
endinterface

// File: rtl/ram_responder.sv
// Single-port word memory answering one request at a time after a fixed LATENCY.
// Define RAM_RANGE_CHECK_EN to flag out-of-range addresses on err instead of wrapping.
module ram_responder #(
    parameter int SIZE_RAM = 4096,
    parameter int LATENCY  = 4
) (
    input  logic            clk,
    input  logic            rst,
    ram_responder_if.slave  bus
);
    localparam int IDX_W = $clog2(SIZE_RAM);
    localparam int CNT_W = $clog2(LATENCY + 1);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               response_q, response_d;
    logic               valid_q, valid_d;
    logic [31:0]        out_q, out_d;
    logic               mode_q, mode_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [31:0]        wdata_q, wdata_d;
    logic               mem_we;

    logic [31:0]        mem [SIZE_RAM];

`ifdef RAM_RANGE_CHECK_EN
    logic               oor_q, oor_d;
    logic               err_q, err_d;
`else
    logic               unused_addr_hi;
    assign unused_addr_hi = ^bus.address[31:IDX_W];
`endif

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        response_d = response_q;
        valid_d    = 1'b0;
        out_d      = out_q;
        mode_d     = mode_q;
        idx_d      = idx_q;
        wdata_d    = wdata_q;
        mem_we     = 1'b0;
`ifdef RAM_RANGE_CHECK_EN
        oor_d      = oor_q;
        err_d      = err_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.req) begin
                    state_d    = BUSY;
                    cnt_d      = CNT_W'(LATENCY);
                    response_d = 1'b1;
                    mode_d     = bus.mode;
                    idx_d      = bus.address[IDX_W-1:0];
                    wdata_d    = bus.data;
`ifdef RAM_RANGE_CHECK_EN
                    oor_d      = |bus.address[31:IDX_W];
`endif
                end
            end
            BUSY: begin
                if (cnt_q > CNT_W'(1)) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    // Completion edge: the access uses only the values captured at acceptance.
                    state_d    = IDLE;
                    cnt_d      = '0;
                    response_d = 1'b0;
                    valid_d    = 1'b1;
`ifdef RAM_RANGE_CHECK_EN
                    err_d      = oor_q;
                    if (!oor_q) begin
                        if (mode_q) mem_we = 1'b1;
                        else        out_d  = mem[idx_q];
                    end
`else
                    if (mode_q) mem_we = 1'b1;
                    else        out_d  = mem[idx_q];
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            response_q <= 1'b0;
            valid_q    <= 1'b0;
            out_q      <= '0;
`ifdef RAM_RANGE_CHECK_EN
            err_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            response_q <= response_d;
            valid_q    <= valid_d;
            out_q      <= out_d;
`ifdef RAM_RANGE_CHECK_EN
            err_q      <= err_d;
`endif
        end
    end

    // Request capture registers need no reset: they are only read while BUSY.
    always_ff @(posedge clk) begin
        mode_q  <= mode_d;
        idx_q   <= idx_d;
        wdata_q <= wdata_d;
`ifdef RAM_RANGE_CHECK_EN
        oor_q   <= oor_d;
`endif
    end

    always_ff @(posedge clk) begin
        if (mem_we) mem[idx_q] <= wdata_q;
    end

    assign bus.response = response_q;
    assign bus.valid    = valid_q;
    assign bus.out      = out_q;
`ifdef RAM_RANGE_CHECK_EN
    assign bus.err      = err_q;
`endif

endmodule

// File: tb/tb_ram_responder.sv
// Bench for ram_responder: transaction-level reference model plus directed and random stimulus.
module tb_ram_responder;
    localparam int SIZE_RAM = 4096;
    localparam int LATENCY  = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ram_responder_if bus();

    ram_responder #(.SIZE_RAM(SIZE_RAM), .LATENCY(LATENCY)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int vectors     = 0;
    int miscompares = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a request is a record with a completion timestamp.
    bit [31:0]   m_mem [int unsigned];
    int unsigned m_cyc;
    int unsigned m_done_at;
    bit          m_busy;
    bit          m_valid;
    bit          m_mode;
    logic [31:0] m_addr;
    logic [31:0] m_data;
    logic [31:0] m_out;
    bit          m_out_known;
    bit          m_err;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_cyc = 0; m_busy = 0; m_valid = 0;
            m_out = 32'h0; m_out_known = 1; m_err = 0;
        end else begin
            m_cyc++;
            m_valid = 0;
            if (m_busy) begin
                if (m_cyc == m_done_at) begin
                    int unsigned idx;
                    bit do_access;
                    idx = m_addr % SIZE_RAM;
                    m_busy = 0;
                    m_valid = 1;
                    do_access = 1;
`ifdef RAM_RANGE_CHECK_EN
                    m_err = (m_addr >= SIZE_RAM);
                    do_access = !m_err;
`endif
                    if (do_access) begin
                        if (m_mode) m_mem[idx] = m_data;
                        else if (m_mem.exists(idx)) begin m_out = m_mem[idx]; m_out_known = 1; end
                        else m_out_known = 0;
                    end
                end
            end else if (bus.req === 1'b1) begin
                m_busy = 1;
                m_done_at = m_cyc + LATENCY;
                m_mode = bus.mode;
                m_addr = bus.address;
                m_data = bus.data;
            end
        end
    end

    always @(negedge clk) begin
        check("response", {31'b0, bus.response}, {31'b0, m_busy});
        check("valid", {31'b0, bus.valid}, {31'b0, m_valid});
        if (m_out_known) check("out", bus.out, m_out);
`ifdef RAM_RANGE_CHECK_EN
        check("err", {31'b0, bus.err}, {31'b0, m_err});
`endif
    end

    task automatic txn(input bit m, input logic [31:0] a, input logic [31:0] d,
                       output int busy, output logic [31:0] rd);
        bit seen;
        busy = 0;
        seen = 0;
        bus.req = 1'b1; bus.mode = m; bus.address = a; bus.data = d;
        @(posedge clk); #1;
        bus.req = 1'b0;
        for (int i = 0; i < LATENCY + 4 && !seen; i++) begin
            @(negedge clk);
            if (bus.response) busy++;
            if (bus.valid) seen = 1;
        end
        check("txn_done", {31'b0, seen}, 32'd1);
        rd = bus.out;
    endtask

    initial begin
        int          busy;
        logic [31:0] rd;
        int          vidx [$];
        int          nvalid;

        bus.req = 1'b0; bus.mode = 1'b0; bus.address = '0; bus.data = '0;
        repeat (3) @(negedge clk);
        check("rst_response", {31'b0, bus.response}, 32'd0);
        check("rst_valid", {31'b0, bus.valid}, 32'd0);
        check("rst_out", bus.out, 32'h0);
        #2 rst = 1'b0;

        txn(1'b1, 32'h010, 32'hDEADBEEF, busy, rd);
        check("wr_busy_cycles", busy, LATENCY);
        check("wr_out_unchanged", rd, 32'h0);
        txn(1'b0, 32'h010, 32'h0, busy, rd);
        check("rd_busy_cycles", busy, LATENCY);
        check("rd_deadbeef", rd, 32'hDEADBEEF);
        check("model_deadbeef", m_out, 32'hDEADBEEF);

        // Request while busy must be dropped.
        txn(1'b1, 32'h020, 32'h11112222, busy, rd);
        bus.req = 1'b1; bus.mode = 1'b0; bus.address = 32'h020;
        @(posedge clk); #1 bus.req = 1'b0;
        repeat (2) @(posedge clk);
        #1 bus.req = 1'b1; bus.mode = 1'b1; bus.data = 32'h12345678;
        @(posedge clk); #1 bus.req = 1'b0;
        repeat (LATENCY + 2) @(negedge clk);
        txn(1'b0, 32'h020, 32'h0, busy, rd);
        check("busy_reject", rd, 32'h11112222);

        txn(1'b1, 32'h005, 32'h55550005, busy, rd);
        txn(1'b1, 32'h1005, 32'hA5A5A5A5, busy, rd);
`ifdef RAM_RANGE_CHECK_EN
        check("oor_err_set", {31'b0, bus.err}, 32'd1);
        txn(1'b0, 32'h005, 32'h0, busy, rd);
        check("oor_no_write", rd, 32'h55550005);
        check("oor_err_clear", {31'b0, bus.err}, 32'd0);
`else
        txn(1'b0, 32'h005, 32'h0, busy, rd);
        check("wrap_read", rd, 32'hA5A5A5A5);
`endif

        // Asynchronous reset in the middle of a write.
        txn(1'b1, 32'h030, 32'h33334444, busy, rd);
        txn(1'b0, 32'h030, 32'h0, busy, rd);
        check("pre_rst_out", rd, 32'h33334444);
        bus.req = 1'b1; bus.mode = 1'b1; bus.address = 32'h030; bus.data = 32'h0BADF00D;
        @(posedge clk); #1 bus.req = 1'b0;
        repeat (2) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check("async_rst_response", {31'b0, bus.response}, 32'd0);
        check("async_rst_valid", {31'b0, bus.valid}, 32'd0);
        check("async_rst_out", bus.out, 32'h0);
        @(negedge clk); #2 rst = 1'b0;
        txn(1'b0, 32'h030, 32'h0, busy, rd);
        check("rst_aborts_write", rd, 32'h33334444);

        // Back-to-back with req held high.
        txn(1'b1, 32'h040, 32'h40404040, busy, rd);
        txn(1'b1, 32'h041, 32'h41414141, busy, rd);
        bus.req = 1'b1; bus.mode = 1'b0; bus.address = 32'h040;
        for (int i = 0; i < 5 * LATENCY; i++) begin
            @(posedge clk); #1;
            if (i == 5 * LATENCY - 1) bus.req = 1'b0;
            else bus.address = (i % 2) ? 32'h040 : 32'h041;
            @(negedge clk);
            if (bus.valid) vidx.push_back(i);
        end
        nvalid = vidx.size();
        check("b2b_valid_count", nvalid, LATENCY);
        for (int k = 1; k < vidx.size(); k++)
            check("b2b_period", vidx[k] - vidx[k-1], LATENCY + 1);

        // Random traffic; the model follows whatever the DUT samples.
        for (int i = 0; i < 600; i++) begin
            @(negedge clk); #1;
            bus.req     = ($urandom_range(0, 2) == 0);
            bus.mode    = $urandom_range(0, 1);
            bus.address = $urandom_range(0, 7) | (($urandom_range(0, 7) == 0) ? 32'h1000 : 32'h0);
            bus.data    = $urandom;
        end
        bus.req = 1'b0;
        repeat (LATENCY + 3) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

endmodule
